// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: shared LC3 instruction/data memory with per-port latency and
// one-cycle completion pulses; data accesses win over fetches, one access at a time.
module lc3_mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int INSTR_LAT = 1,
    parameter int DATA_LAT  = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        instrmem_rd,
    input  logic [15:0] pc,
    output logic [15:0] Instr_dout,
    output logic        complete_instr,
    input  logic        data_req,
    input  logic        Data_rd,
    input  logic [15:0] Data_addr,
    input  logic [15:0] Data_din,
    output logic [15:0] Data_dout,
    output logic        complete_data,
    input  logic        ld_en,
    input  logic [15:0] ld_addr,
    input  logic [15:0] ld_data,
    output logic        mem_busy
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam logic [7:0] ILAT = 8'(INSTR_LAT);
    localparam logic [7:0] DLAT = 8'(DATA_LAT);

    logic [15:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic              rd_q, rd_d;
    logic              data_q, data_d;
    logic [15:0]       instr_dout_q, instr_dout_d;
    logic [15:0]       data_dout_q, data_dout_d;
    logic              cinstr_q, cinstr_d;
    logic              cdata_q, cdata_d;

    logic [ADDR_W-1:0] acc_addr;
    logic [15:0]       acc_din, rd_word;
    logic              acc_rd, acc_data, done_entry, wr_en;
    logic [7:0]        lat;

    // The acc_* view is the access that would complete at this edge: the live
    // request when a 1-cycle access is accepted, otherwise the latched one.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        din_d        = din_q;
        rd_d         = rd_q;
        data_d       = data_q;
        instr_dout_d = instr_dout_q;
        data_dout_d  = data_dout_q;
        cinstr_d     = 1'b0;
        cdata_d      = 1'b0;
        acc_addr     = addr_q;
        acc_din      = din_q;
        acc_rd       = rd_q;
        acc_data     = data_q;
        lat          = DLAT;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: if (data_req || instrmem_rd) begin
                acc_data = data_req;
                acc_rd   = Data_rd;
                acc_addr = data_req ? Data_addr[ADDR_W-1:0] : pc[ADDR_W-1:0];
                acc_din  = Data_din;
                lat      = data_req ? DLAT : ILAT;
                cnt_d    = lat - 8'd1;
                state_d  = (lat == 8'd1) ? DONE : WAIT;
                addr_d   = acc_addr;
                din_d    = acc_din;
                rd_d     = acc_rd;
                data_d   = acc_data;
            end
            WAIT: begin
                cnt_d   = cnt_q - 8'd1;
                state_d = (cnt_q == 8'd1) ? DONE : WAIT;
            end
            default: state_d = IDLE;
        endcase
        done_entry = (state_d == DONE) && (state_q != DONE);
        rd_word    = mem[acc_addr];
        if (done_entry) begin
            cinstr_d = !acc_data;
            cdata_d  = acc_data;
            if (!acc_data)
                instr_dout_d = rd_word;
            else if (acc_rd)
                data_dout_d = rd_word;
            else
                wr_en = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            din_q        <= '0;
            rd_q         <= 1'b0;
            data_q       <= 1'b0;
            instr_dout_q <= '0;
            data_dout_q  <= '0;
            cinstr_q     <= 1'b0;
            cdata_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            din_q        <= din_d;
            rd_q         <= rd_d;
            data_q       <= data_d;
            instr_dout_q <= instr_dout_d;
            data_dout_q  <= data_dout_d;
            cinstr_q     <= cinstr_d;
            cdata_q      <= cdata_d;
        end
    end

    // Core write is placed last so it overrides a same-edge preload.
    always_ff @(posedge clock) begin
        if (ld_en)
            mem[ld_addr[ADDR_W-1:0]] <= ld_data;
        if (wr_en && !reset)
            mem[acc_addr] <= acc_din;
    end

    assign Instr_dout     = instr_dout_q;
    assign Data_dout      = data_dout_q;
    assign complete_instr = cinstr_q;
    assign complete_data  = cdata_q;
    assign mem_busy       = state_q != IDLE;
endmodule

// File: tb/tb_lc3_mem_responder.sv
// tb_lc3_mem_responder: directed and random checks of the memory responder against
// a cycle-time transaction model of the array, latencies and completion pulses.
module tb_lc3_mem_responder;
    localparam int AW = 12;
    localparam int IL = 1;
    localparam int DL = 2;

    logic        clock = 1'b0, reset = 1'b1;
    logic        instrmem_rd = 1'b0, data_req = 1'b0, Data_rd = 1'b0, ld_en = 1'b0;
    logic [15:0] pc = '0, Data_addr = '0, Data_din = '0, ld_addr = '0, ld_data = '0;
    logic [15:0] Instr_dout, Data_dout;
    logic        complete_instr, complete_data, mem_busy;

    int checks = 0, errors = 0;

    lc3_mem_responder #(.ADDR_W(AW), .INSTR_LAT(IL), .DATA_LAT(DL)) dut (
        .clock(clock), .reset(reset), .instrmem_rd(instrmem_rd), .pc(pc),
        .Instr_dout(Instr_dout), .complete_instr(complete_instr), .data_req(data_req),
        .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din), .Data_dout(Data_dout),
        .complete_data(complete_data), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .mem_busy(mem_busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: an access accepted at edge e with latency L completes at edge e+L-1
    // and the responder accepts again no earlier than edge e+L+1.
    logic [15:0] m [2**AW];
    int          now = 0, next_acc = 0, t_done = 0;
    logic        p_valid = 1'b0, p_data = 1'b0, p_rd = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [15:0] p_din = '0, e_id = '0, e_dd = '0;
    logic        e_ci = 1'b0, e_cd = 1'b0, e_busy = 1'b0;

    always @(posedge clock or posedge reset) begin
        int lat;
        logic [15:0] rdv;
        if (reset) begin
            p_valid = 1'b0; e_ci = 1'b0; e_cd = 1'b0; e_id = '0; e_dd = '0;
            e_busy = 1'b0; next_acc = 0;
        end else begin
            now++;
            e_ci = 1'b0;
            e_cd = 1'b0;
            if (!p_valid && now >= next_acc && (data_req || instrmem_rd)) begin
                p_valid = 1'b1;
                p_data = data_req;
                p_rd = Data_rd;
                p_addr = data_req ? Data_addr[AW-1:0] : pc[AW-1:0];
                p_din = Data_din;
                lat = data_req ? DL : IL;
                t_done = now + lat - 1;
                next_acc = now + lat + 1;
            end
            e_busy = now < next_acc - 1;
            rdv = m[p_addr];
            if (ld_en) m[ld_addr[AW-1:0]] = ld_data;
            if (p_valid && now == t_done) begin
                p_valid = 1'b0;
                if (!p_data) begin
                    e_ci = 1'b1;
                    e_id = rdv;
                end else begin
                    e_cd = 1'b1;
                    if (p_rd) e_dd = rdv;
                    else m[p_addr] = p_din;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (!reset) begin
            chk("complete_instr", {15'b0, complete_instr}, {15'b0, e_ci});
            chk("complete_data", {15'b0, complete_data}, {15'b0, e_cd});
            chk("Instr_dout", Instr_dout, e_id);
            chk("Data_dout", Data_dout, e_dd);
            chk("mem_busy", {15'b0, mem_busy}, {15'b0, e_busy});
            chk("pulse_exclusive", {15'b0, complete_instr & complete_data}, 16'h0);
        end
    end

    task automatic wait_pulse(input bit which, input int maxn, output int n);
        n = 0;
        for (int i = 1; i <= maxn; i++) begin
            @(negedge clock);
            if ((which ? complete_data : complete_instr) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic fetch(input logic [15:0] a, output int n);
        pc = a;
        instrmem_rd = 1'b1;
        wait_pulse(1'b0, 20, n);
        instrmem_rd = 1'b0;
    endtask

    task automatic dacc(input logic rd, input logic [15:0] a, input logic [15:0] d, output int n);
        Data_rd = rd;
        Data_addr = a;
        Data_din = d;
        data_req = 1'b1;
        wait_pulse(1'b1, 20, n);
        data_req = 1'b0;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clock);
        ld_en = 1'b0;
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clock);
        chk("reset_instr_dout", Instr_dout, 16'h0);
        chk("reset_data_dout", Data_dout, 16'h0);
        chk("reset_pulses", {14'b0, complete_instr, complete_data}, 16'h0);
        chk("reset_busy", {15'b0, mem_busy}, 16'h0);
        reset = 1'b0;
        for (int i = 0; i < 2**AW; i++) preload(16'(i), 16'($urandom));

        // Held fetch: pulse one cycle after acceptance, then every two cycles.
        preload(16'h3000, 16'h1234);
        pc = 16'h3000;
        instrmem_rd = 1'b1;
        wait_pulse(1'b0, 20, n);
        chk("fetch_latency", 16'(n), 16'd1);
        chk("fetch_word", Instr_dout, 16'h1234);
        wait_pulse(1'b0, 20, n);
        chk("fetch_spacing", 16'(n), 16'd2);
        instrmem_rd = 1'b0;
        repeat (2) @(negedge clock);

        dacc(1'b0, 16'h4000, 16'hBEEF, n);
        chk("write_latency", 16'(n), 16'd2);
        repeat (2) @(negedge clock);
        dacc(1'b1, 16'h4000, 16'h0, n);
        chk("read_latency", 16'(n), 16'd2);
        chk("read_after_write", Data_dout, 16'hBEEF);
        repeat (2) @(negedge clock);

        // Simultaneous requests: data first, fetch re-sampled after DONE.
        preload(16'h0456, 16'hCAFE);
        Data_rd = 1'b1;
        Data_addr = 16'h0123;
        pc = 16'h0456;
        data_req = 1'b1;
        instrmem_rd = 1'b1;
        wait_pulse(1'b1, 20, n);
        data_req = 1'b0;
        chk("prio_data_latency", 16'(n), 16'd2);
        wait_pulse(1'b0, 20, n);
        instrmem_rd = 1'b0;
        chk("prio_fetch_after", 16'(n), 16'd2);
        chk("prio_fetch_word", Instr_dout, 16'hCAFE);
        repeat (2) @(negedge clock);

        // Address wrap with a 12-bit array.
        preload(16'h0FFF, 16'hA5A5);
        preload(16'h0000, 16'h5A5A);
        fetch(16'h3FFF, n);
        chk("wrap_fetch_3fff", Instr_dout, 16'hA5A5);
        fetch(16'h4000, n);
        chk("wrap_fetch_4000", Instr_dout, 16'h5A5A);
        repeat (2) @(negedge clock);

        // Reset while a write is in WAIT: the write is abandoned.
        Data_rd = 1'b0;
        Data_addr = 16'h5000;
        Data_din = 16'h7777;
        data_req = 1'b1;
        @(posedge clock);
        #1;
        data_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_outputs", Instr_dout | Data_dout, 16'h0);
        chk("rst_mid_pulses", {14'b0, complete_instr, complete_data}, 16'h0);
        chk("rst_mid_busy", {15'b0, mem_busy}, 16'h0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (2) @(negedge clock);
        dacc(1'b1, 16'h5000, 16'h0, n);
        chk("rst_write_dropped", Data_dout, 16'h5A5A);
        repeat (2) @(negedge clock);

        // Preload colliding with a committing write: the write wins.
        ld_en = 1'b1;
        ld_addr = 16'h00AB;
        ld_data = 16'h2222;
        dacc(1'b0, 16'h00AB, 16'h1111, n);
        ld_en = 1'b0;
        repeat (2) @(negedge clock);
        dacc(1'b1, 16'h00AB, 16'h0, n);
        chk("collide_write_wins", Data_dout, 16'h1111);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            data_req = ($urandom_range(0, 9) < 3);
            instrmem_rd = ($urandom_range(0, 1) == 1);
            Data_rd = ($urandom_range(0, 1) == 1);
            Data_addr = 16'($urandom);
            Data_din = 16'($urandom);
            pc = 16'($urandom);
            ld_en = ($urandom_range(0, 9) == 0);
            ld_addr = 16'($urandom);
            ld_data = 16'($urandom);
        end
        data_req = 1'b0;
        instrmem_rd = 1'b0;
        ld_en = 1'b0;
        repeat (5) @(negedge clock);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
